alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Command-level controller that owns the 8-bit ALU and sequences one operation at a time. It accepts a binary opcode plus operands over a valid/ready command interface, decodes the opcode to the ALU's one-hot selector, and waits out the ALU's registered latency. It then captures the result and presents it on a valid/ready response interface. It sits between the processor's instruction/control logic and the ALU instance.

Parameters:
DATA_W, 8, operand/result width; fixed at 8 to match the ALU, checked at elaboration.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  4  opcode: 0 ADD, 1 SUB, 2 NOT, 3 NAND, 4 NOR, 5 AND, 6 XOR, 7 OR, 8 XNOR; 9-15 illegal
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_W  captured result ({alu_left, alu_right})
rsp_negative  out  1  captured ALU negative flag
rsp_error  out  1  illegal opcode
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_selector  out  16  to ALU one-hot selector
alu_negative  in  1  from ALU
alu_left  in  4  from ALU, result[7:4]
alu_right  in  4  from ALU, result[3:0]
busy  out  1  state != IDLE
op_count  out  CNT_W  completed legal operations

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-low (rst_n sampled on clk rising edge).
- Reset values:
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_negative=0, rsp_error=0.
  - alu_selector=0, alu_a=0, alu_b=0, op_count=0.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register op/a/b.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with rsp_error=1, rsp_result=0, rsp_negative=0; the ALU is never driven.
- ISSUE (one cycle):
  - alu_a/alu_b hold the registered operands.
  - alu_selector = 1<<op, exactly one bit set. The ALU registers its result at the end of this cycle.
  - Next state: CAPTURE.
- CAPTURE (one cycle):
  - alu_selector=0.
  - At the end of the cycle, latch rsp_result={alu_left,alu_right}, rsp_negative=alu_negative, rsp_error=0.
  - Increment op_count; it wraps at 2^CNT_W-1 -> 0.
  - Next state: RESP.
- RESP:
  - rsp_valid=1. Outputs are held stable until rsp_valid&rsp_ready.
  - After the handshake, go to IDLE.
  - No same-cycle bypass: cmd_ready rises in the cycle after the response handshake.
- Outside ISSUE, alu_selector=0 always, so the ALU holds its value. The controller never depends on the ALU's unreset state before the first CAPTURE.
- Latency:
  - Legal op: accept edge -> rsp_valid high 3 cycles later.
  - Illegal op: rsp_valid high 1 cycle later.
  - Maximum throughput is one op per 4 cycles.
- One outstanding command only; cmd_ready=0 in all states except IDLE.
- SUB semantics are passed through unmodified. For a<=b the result is b-a with negative=1, including a==b, which gives result 0 with negative=1.
- Reset mid-operation:
  - Return to IDLE and drop any in-flight op with no response.
  - alu_selector=0 in the same cycle reset is sampled. The ALU may already hold the dropped result; this is harmless.

Optional Feature:
ALU_SEQ_CHAIN_EN:
- Defined: adds input port cmd_chain (1 bit).
  - When it is 1 at acceptance, operand A is the last captured legal rsp_result instead of cmd_a.
  - The chain register resets to 0 and is not updated by illegal ops.
- Undefined: no cmd_chain port; operand A is always cmd_a.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum constants.
  - opcode constants OP_ADD..OP_XNOR and OP_LAST=8.
  - SEL_W=16.
  - function/constant for the illegal-opcode test.
- Sub-module alu_op_decode: combinational cmd_op -> 16-bit one-hot plus an illegal flag, instantiated once.

Test Plan:
- ADD a=0x25 b=0x13 -> rsp_result=0x38, negative=0, error=0. rsp_valid 3 cycles after accept; alu_selector=0x0001 for exactly one cycle.
- SUB a=0x03 b=0x0A -> result=0x07, negative=1. SUB a=0x05 b=0x05 -> result=0x00, negative=1. SUB a=0x0A b=0x03 -> 0x07, negative=0.
- cmd_op=0xC -> rsp_valid 1 cycle after accept, error=1, result=0x00. alu_selector stays 0 throughout; op_count unchanged.
- XNOR 0xF0,0xCC with rsp_ready low 5 cycles -> result=0xC3 held stable, cmd_ready=0 throughout. cmd_ready=1 the cycle after the handshake.
- rst_n low during ISSUE of an ADD -> next cycle IDLE, alu_selector=0, no rsp_valid. The following AND 0xAA,0x0F returns 0x0A.
- (ALU_SEQ_CHAIN_EN) ADD 0x10+0x01 = 0x11, then chained ADD b=0x02 -> 0x13. op_count=2.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int SEL_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } seq_state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_LAST = OP_XNOR;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command and response handshake bundle for alu_sequencer.
// cmd_chain exists only when ALU_SEQ_CHAIN_EN is defined.
interface alu_seq_if #(parameter int DATA_W = 8);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
    logic              cmd_chain;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_negative;
    logic              rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
        output cmd_chain,
`endif
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_negative, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
        input  cmd_chain,
`endif
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_negative, rsp_error
    );
endinterface

// File: rtl/alu_op_decode.sv
// Binary opcode to one-hot ALU selector, flagging opcodes the ALU lacks.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0]       op,
    output logic [SEL_W-1:0] onehot,
    output logic             illegal
);

    always_comb begin
        illegal = op_is_illegal(op);
        onehot  = '0;
        if (!illegal) onehot[op] = 1'b1;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time between a command and a response handshake.
// Optional ALU_SEQ_CHAIN_EN: cmd_chain substitutes the last legal result for operand A.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_if.slave          bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_selector,
    input  logic              alu_negative,
    input  logic [3:0]        alu_left,
    input  logic [3:0]        alu_right,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    if (DATA_W != 8) begin : g_width_check
        $error("alu_sequencer: DATA_W must be 8 to match the ALU");
    end

    seq_state_t        state;
    logic [SEL_W-1:0]  dec_onehot;
    logic              dec_illegal;
    logic [DATA_W-1:0] operand_a;

    alu_op_decode u_decode (
        .op      (bus.cmd_op),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

`ifdef ALU_SEQ_CHAIN_EN
    logic [DATA_W-1:0] chain_q;
    assign operand_a = bus.cmd_chain ? chain_q : bus.cmd_a;
`else
    assign operand_a = bus.cmd_a;
`endif

    assign busy = (state != IDLE);

    // Operands and selector are loaded straight into the ALU-facing registers on
    // acceptance, so ISSUE presents them without an extra pipeline stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.cmd_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_negative <= 1'b0;
            bus.rsp_error    <= 1'b0;
            alu_selector     <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            op_count         <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        if (dec_illegal) begin
                            state            <= RESP;
                            bus.rsp_valid    <= 1'b1;
                            bus.rsp_result   <= '0;
                            bus.rsp_negative <= 1'b0;
                            bus.rsp_error    <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            alu_a        <= operand_a;
                            alu_b        <= bus.cmd_b;
                            alu_selector <= dec_onehot;
                        end
                    end
                end
                ISSUE: begin
                    alu_selector <= '0;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    bus.rsp_result   <= {alu_left, alu_right};
                    bus.rsp_negative <= alu_negative;
                    bus.rsp_error    <= 1'b0;
                    bus.rsp_valid    <= 1'b1;
                    op_count         <= op_count + CNT_W'(1);
`ifdef ALU_SEQ_CHAIN_EN
                    chain_q          <= {alu_left, alu_right};
`endif
                    state            <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    alu_selector <= '0;
                end
            endcase
        end
    end

endmodule
